// File: rtl/fir_pkg.sv
// Shared definitions for the 8-bit signed FIR datapath and its back-end stages.
package fir_pkg;

  localparam int N_DEF = 8;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic logic signed [31:0] sat_signed(
    input logic signed [31:0] v,
    input int                 width
  );
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (width - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (width - 1));
    if (v > hi)      return hi;
    else if (v < lo) return lo;
    else             return v;
  endfunction

endpackage

// File: rtl/fir_dec_fifo.sv
// Synchronous show-ahead FIFO; head word is visible whenever not empty.
module fir_dec_fifo
  import fir_pkg::*;
#(
  parameter int W     = N_DEF,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           din,
  output logic [W-1:0]           dout,
  output logic                   full,
  output logic                   empty,
  output logic [clog2(DEPTH):0]  level
);

  localparam int AW = clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wptr;
  logic [AW:0]  rptr;
  logic         wr;
  logic         rd;

  assign level = wptr - rptr;
  assign full  = (level == (AW + 1)'(DEPTH));
  assign empty = (wptr == rptr);
  assign rd    = pop & ~empty;
  assign wr    = push & (~full | rd);
  assign dout  = mem[rptr[AW-1:0]];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr <= '0;
      rptr <= '0;
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else begin
      if (wr) begin
        mem[wptr[AW-1:0]] <= din;
        wptr              <= wptr + 1'b1;
      end
      if (rd)
        rptr <= rptr + 1'b1;
    end
  end

endmodule

// File: rtl/fir_decimator.sv
// Integrate-and-dump decimator: primes, sums DECIM samples, scales,
// saturates and queues results for a valid/ready consumer.
module fir_decimator
  import fir_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int DECIM = 4,
  parameter int SHIFT = 2,
  parameter int DEPTH = 4,
  parameter int PRIME = 6
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   in_valid,
  input  logic [N-1:0]           data_in,
  input  logic                   dec_ready,
  output logic                   dec_valid,
  output logic [N-1:0]           dec_data,
  output logic [clog2(DEPTH):0]  fifo_level,
  output logic                   sat_pulse,
  output logic                   overflow,
  input  logic                   clr_overflow
);

  localparam int AW = N + clog2(DECIM);
  localparam int PW = clog2(DECIM);
  localparam int CW = (PRIME > 0) ? clog2(PRIME + 1) : 1;

  logic [CW-1:0]        prime_cnt;
  logic                 primed;
  logic [PW-1:0]        phase;
  logic signed [AW-1:0] acc;
  logic signed [AW-1:0] sum;
  logic signed [AW-1:0] scaled;
  logic signed [31:0]   scaled32;
  logic signed [31:0]   sat_val;
  logic                 last;

  logic                 r_valid;
  logic                 r_sat;
  logic [N-1:0]         r_data;

  logic                 pop;
  logic                 full;
  logic                 empty;
  logic                 accept;
  logic                 drop;

  assign primed   = (prime_cnt == CW'(PRIME));
  assign last     = in_valid & primed & (phase == PW'(DECIM - 1));
  assign sum      = acc + {{(AW-N){data_in[N-1]}}, data_in};
  assign scaled   = sum >>> SHIFT;
  assign scaled32 = $signed({{(32-AW){scaled[AW-1]}}, scaled});
  assign sat_val  = sat_signed(scaled32, N);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prime_cnt <= '0;
      phase     <= '0;
      acc       <= '0;
      r_valid   <= 1'b0;
      r_sat     <= 1'b0;
      r_data    <= '0;
    end else begin
      r_valid <= last;
      if (last) begin
        r_data <= sat_val[N-1:0];
        r_sat  <= (sat_val != scaled32);
      end
      if (in_valid) begin
        if (!primed) begin
          prime_cnt <= prime_cnt + 1'b1;
        end else if (last) begin
          acc   <= '0;
          phase <= '0;
        end else begin
          acc   <= sum;
          phase <= phase + 1'b1;
        end
      end
    end
  end

  // A full FIFO still takes the result if the head leaves this cycle.
  assign pop       = dec_valid & dec_ready;
  assign accept    = r_valid & (~full | pop);
  assign drop      = r_valid & full & ~pop;
  assign sat_pulse = accept & r_sat;
  assign dec_valid = ~empty;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      overflow <= 1'b0;
    else if (drop)
      overflow <= 1'b1;
    else if (clr_overflow)
      overflow <= 1'b0;
  end

  fir_dec_fifo #(
    .W     (N),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (accept),
    .pop     (pop),
    .din     (r_data),
    .dout    (dec_data),
    .full    (full),
    .empty   (empty),
    .level   (fifo_level)
  );

endmodule
